// File: rtl/hbm_port_rr_arbiter.sv
// Round-robin arbiter sharing one HBM pseudo-channel command port among NUM_REQ requesters,
// issuing one command per grant and throttling against an outstanding-command credit limit.
module hbm_port_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 34,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAX_OUT = 8,
  localparam int unsigned ID_W   = $clog2(NUM_REQ),
  localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  input  logic [NUM_REQ-1:0]          req_write,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [ADDR_W-1:0]           cmd_addr,
  output logic [LEN_W-1:0]            cmd_len,
  output logic                        cmd_write,
  output logic [ID_W-1:0]             cmd_id,
  input  logic                        cmp_valid,
  output logic [OUT_W-1:0]            outstanding,
  output logic                        err_underflow
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               write_q, write_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               err_q, err_d;

  logic [ID_W-1:0]    winner;
  logic               found;
  logic               grant;
  logic               hs;

  // First valid requester scanning upward from rr_ptr with wrap
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Arbitration uses the registered credit count
  assign grant     = !sys_rst && (state_q == IDLE) && found && (out_q < OUT_W'(MAX_OUT));
  assign hs        = (state_q == ISSUE) && cmd_ready;
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    write_d  = write_q;
    id_d     = id_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = ISSUE;
          addr_d   = req_addr[winner*ADDR_W +: ADDR_W];
          len_d    = req_len[winner*LEN_W +: LEN_W];
          write_d  = req_write[winner];
          id_d     = winner;
          rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
      end
      ISSUE: begin
        if (cmd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter: issue adds, completion frees; simultaneous events cancel
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (hs && !cmp_valid) begin
      out_d = out_q + OUT_W'(1);
    end else if (!hs && cmp_valid) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - OUT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      write_q  <= 1'b0;
      id_q     <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      write_q  <= write_d;
      id_q     <= id_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign cmd_valid     = (state_q == ISSUE);
  assign cmd_addr      = addr_q;
  assign cmd_len       = len_q;
  assign cmd_write     = write_q;
  assign cmd_id        = id_q;
  assign outstanding   = out_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_hbm_port_rr_arbiter.sv
// Directed bench for hbm_port_rr_arbiter: expected commands are queued at grant time
// and a negedge monitor compares them against each command-port handshake.
module tb_hbm_port_rr_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 34;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned OUT_W   = 4;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              wr;
  } cmd_t;

  logic                       clk = 1'b0;
  logic                       sys_rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*LEN_W-1:0]   req_len;
  logic [NUM_REQ-1:0]         req_write;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [ADDR_W-1:0]          cmd_addr;
  logic [LEN_W-1:0]           cmd_len;
  logic                       cmd_write;
  logic [ID_W-1:0]            cmd_id;
  logic                       cmp_valid;
  logic [OUT_W-1:0]           outstanding;
  logic                       err_underflow;

  cmd_t sb[$];
  cmd_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hs     = 0;
  int   n_push   = 0;

  hbm_port_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_write(req_write),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmp_valid(cmp_valid), .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Requester i: addr 0x1000 + i*4G, len 15 + 16*i, even ids write
  function automatic cmd_t exp_cmd(input int unsigned i);
    cmd_t c;
    c.id   = ID_W'(i);
    c.addr = 34'h1000 + 34'(i) * 34'h1_0000_0000;
    c.len  = LEN_W'(15 + 16 * i);
    c.wr   = ~i[0];
    return c;
  endfunction

  function automatic logic [NUM_REQ-1:0] ohot(input int unsigned i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      n_hs++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cmd: got id %0d addr 0x%0h, expected no command", cmd_id, cmd_addr);
      end else begin
        mon_e = sb.pop_front();
        check("cmd_fields", 64'({cmd_id, cmd_addr, cmd_len, cmd_write}), 64'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned i);
    sb.push_back(exp_cmd(i));
    n_push++;
  endtask

  task automatic do_reset();
    sys_rst   = 1'b1;
    req_valid = '0;
    cmp_valid = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  // Single requester grant-and-issue; needs cmd_ready=1 and a free credit
  task automatic issue_one(input int unsigned i);
    req_valid = ohot(i);
    #1;
    check("issue_ready", 64'(req_ready), 64'(ohot(i)));
    push(i);
    tick();
    req_valid = '0;
    tick();
  endtask

  initial begin
    int unsigned ids [6] = '{0, 1, 2, 3, 0, 1};
    sys_rst   = 1'b1;
    req_valid = 4'hf;
    cmd_ready = 1'b0;
    cmp_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = exp_cmd(i).addr;
      req_len[i*LEN_W +: LEN_W]    = exp_cmd(i).len;
      req_write[i]                 = exp_cmd(i).wr;
    end
    tick();
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    do_reset();
    #1;
    check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_err", 64'(err_underflow), 64'(0));
    check("rst_cmd_addr", 64'(cmd_addr), 64'(0));

    // Single command from requester 0
    cmd_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 64'(req_ready), 64'(4'b0001));
    push(0);
    tick();
    req_valid = '0;
    #1;
    check("t1_cmd_valid", 64'(cmd_valid), 64'(1));
    check("t1_ready_issue", 64'(req_ready), 64'(0));
    tick();
    #1;
    check("t1_outstanding", 64'(outstanding), 64'(1));

    // Round robin across all four requesters
    do_reset();
    cmd_ready = 1'b1;
    cmp_valid = 1'b1;
    req_valid = 4'hf;
    foreach (ids[g]) begin
      #1;
      check("t2_grant", 64'(req_ready), 64'(ohot(ids[g])));
      push(ids[g]);
      tick();
      #1;
      check("t2_ready_issue", 64'(req_ready), 64'(0));
      tick();
    end
    req_valid = '0;
    cmp_valid = 1'b0;
    #1;
    check("t2_underflow", 64'(err_underflow), 64'(1));
    check("t2_outstanding", 64'(outstanding), 64'(0));

    // Credit exhaustion at MAX_OUT
    do_reset();
    cmd_ready = 1'b1;
    for (int n = 0; n < 8; n++) issue_one(2);
    #1;
    check("t3_full", 64'(outstanding), 64'(8));
    req_valid = 4'b0100;
    for (int n = 0; n < 4; n++) begin
      #1;
      check("t3_blocked", 64'(req_ready), 64'(0));
      tick();
    end
    cmp_valid = 1'b1;
    #1;
    check("t3_cmp_cycle", 64'(req_ready), 64'(0));
    tick();
    cmp_valid = 1'b0;
    #1;
    check("t3_freed", 64'(outstanding), 64'(7));
    check("t3_regrant", 64'(req_ready), 64'(4'b0100));
    push(2);
    tick();
    tick();
    #1;
    check("t3_refull", 64'(outstanding), 64'(8));
    for (int n = 0; n < 3; n++) begin
      #1;
      check("t3_blocked2", 64'(req_ready), 64'(0));
      tick();
    end
    req_valid = '0;

    // Backpressure holds the command; next grant follows the held id
    do_reset();
    cmd_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("t4_ready", 64'(req_ready), 64'(4'b0001));
    push(0);
    tick();
    req_valid = 4'b1110;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("t4_hold_valid", 64'(cmd_valid), 64'(1));
      check("t4_hold_addr", 64'(cmd_addr), 64'(34'h1000));
      check("t4_hold_len", 64'(cmd_len), 64'(15));
      check("t4_no_ready", 64'(req_ready), 64'(0));
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    #1;
    check("t4_next", 64'(req_ready), 64'(4'b0010));
    push(1);
    tick();
    req_valid = '0;
    tick();

    // Coincident issue/complete, then underflow
    do_reset();
    cmd_ready = 1'b1;
    for (int n = 0; n < 3; n++) issue_one(3);
    #1;
    check("t5_three", 64'(outstanding), 64'(3));
    req_valid = 4'b1000;
    push(3);
    tick();
    req_valid = '0;
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    #1;
    check("t5_net_zero", 64'(outstanding), 64'(3));
    for (int n = 0; n < 3; n++) begin
      cmp_valid = 1'b1;
      tick();
      cmp_valid = 1'b0;
    end
    #1;
    check("t5_drained", 64'(outstanding), 64'(0));
    check("t5_no_err", 64'(err_underflow), 64'(0));
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    #1;
    check("t5_err_set", 64'(err_underflow), 64'(1));
    check("t5_floor", 64'(outstanding), 64'(0));
    tick();
    tick();
    tick();
    check("t5_err_sticky", 64'(err_underflow), 64'(1));
    do_reset();
    #1;
    check("t5_err_cleared", 64'(err_underflow), 64'(0));

    // Reset while a command is held in ISSUE
    cmd_ready = 1'b1;
    issue_one(1);
    issue_one(2);
    issue_one(3);
    issue_one(0);
    issue_one(1);
    cmd_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    check("t6_ready", 64'(req_ready), 64'(4'b0010));
    push(1);
    tick();
    req_valid = '0;
    #1;
    check("t6_issue", 64'(cmd_valid), 64'(1));
    check("t6_five", 64'(outstanding), 64'(5));
    sys_rst = 1'b1;
    tick();
    #1;
    check("t6_rst_valid", 64'(cmd_valid), 64'(0));
    check("t6_rst_out", 64'(outstanding), 64'(0));
    void'(sb.pop_back());
    n_push--;
    sys_rst   = 1'b0;
    cmd_ready = 1'b1;
    req_valid = 4'hf;
    #1;
    check("t6_first_grant", 64'(req_ready), 64'(4'b0001));
    push(0);
    tick();
    req_valid = '0;
    tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
    check("hs_count", 64'(n_hs), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
